// File: rtl/bsg_manycore_pkg.sv
// Shared manycore network definitions: the packet layout macro, opcodes and
// the encoder FSM state type.
`ifndef BSG_MANYCORE_PKG_SV
`define BSG_MANYCORE_PKG_SV

// Packet layout, MSB to LSB; widths are supplied by the instantiating module.
`define BSG_MANYCORE_PACKET_S_DEF(aw, dw, xw, yw) \
    typedef struct packed { \
        logic [5:0]    op; \
        logic [aw-1:0] addr; \
        logic [dw-1:0] data; \
        logic [yw-1:0] from_y_cord; \
        logic [xw-1:0] from_x_cord; \
        logic [yw-1:0] y_cord; \
        logic [xw-1:0] x_cord; \
    } bsg_manycore_packet_s

package bsg_manycore_pkg;

    typedef enum logic [5:0] {
        e_op_remote_store = 6'd1,
        e_op_config       = 6'd2
    } bsg_manycore_op_e;

    typedef enum logic [1:0] {
        e_idle,
        e_fence,
        e_issue
    } encode_state_e;

endpackage

`endif

// File: rtl/bsg_two_fifo.sv
// Two-entry valid/ready queue; ready_o is registered, so a full queue only
// reports space after the dequeue edge.
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

    logic [width_p-1:0] mem [2];
    logic               wptr;
    logic               rptr;
    logic               full;
    logic               empty;
    logic               enq;
    logic               deq;

    assign ready_o = ~full;
    assign v_o     = ~empty;
    assign data_o  = mem[rptr];
    assign enq     = v_i & ~full;
    assign deq     = ~empty & ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (enq) wptr <= ~wptr;
            if (deq) rptr <= ~rptr;
            if (enq & ~deq) begin
                empty <= 1'b0;
                full  <= ~empty;
            end else if (deq & ~enq) begin
                full  <= 1'b0;
                empty <= ~full;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr] <= data_i;
    end

endmodule

// File: rtl/bsg_manycore_pkt_encode.sv
// Transmit-side packet builder: credit-metered remote stores plus config
// packets fenced behind all outstanding stores, through a two-entry queue.
module bsg_manycore_pkt_encode
    import bsg_manycore_pkg::*;
#(
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 16,
    parameter int max_out_credits_p = 16,
    localparam int packet_width_lp  = 6 + addr_width_p + data_width_p
                                      + 2 * (x_cord_width_p + y_cord_width_p),
    localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [x_cord_width_p-1:0]  my_x_i,
    input  logic [y_cord_width_p-1:0]  my_y_i,
    input  logic                       st_v_i,
    input  logic [addr_width_p-1:0]    st_addr_i,
    input  logic [data_width_p-1:0]    st_data_i,
    input  logic [x_cord_width_p-1:0]  st_x_i,
    input  logic [y_cord_width_p-1:0]  st_y_i,
    output logic                       st_ready_o,
    input  logic                       cfg_v_i,
    input  logic                       cfg_freeze_i,
    input  logic [x_cord_width_p-1:0]  cfg_x_i,
    input  logic [y_cord_width_p-1:0]  cfg_y_i,
    output logic                       cfg_ready_o,
    input  logic                       credit_return_i,
    output logic                       v_o,
    output logic [packet_width_lp-1:0] data_o,
    input  logic                       ready_i,
    output logic [credit_width_lp-1:0] out_credits_o
);

    `BSG_MANYCORE_PACKET_S_DEF(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);

    localparam logic [credit_width_lp-1:0] credit_max_lp = credit_width_lp'(max_out_credits_p);

    encode_state_e              state;
    encode_state_e              state_n;
    logic [credit_width_lp-1:0] credits;
    logic                       fifo_ready;
    logic                       fifo_v;
    logic                       st_accept;
    logic                       cfg_accept;
    bsg_manycore_packet_s       enq_pkt;

    assign st_accept     = st_v_i & st_ready_o;
    assign cfg_accept    = cfg_v_i & cfg_ready_o;
    assign out_credits_o = credits;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= e_idle;
        else         state <= state_n;
    end

    // Readies are held low during reset so no request is taken while queue
    // and credits are being cleared.
    always_comb begin
        state_n     = state;
        st_ready_o  = 1'b0;
        cfg_ready_o = 1'b0;
        case (state)
            e_idle: begin
                st_ready_o = fifo_ready & (credits != '0) & ~cfg_v_i & ~reset_i;
                if (cfg_v_i) state_n = e_fence;
            end
            e_fence: begin
                if ((credits == credit_max_lp) && !fifo_v) state_n = e_issue;
            end
            e_issue: begin
                cfg_ready_o = fifo_ready & ~reset_i;
                if (cfg_v_i && cfg_ready_o) state_n = e_idle;
            end
            default: state_n = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            credits <= credit_max_lp;
        end else if (st_accept && !credit_return_i) begin
            credits <= credits - credit_width_lp'(1);
        end else if (credit_return_i && !st_accept && (credits != credit_max_lp)) begin
            credits <= credits + credit_width_lp'(1);
        end
    end

    always_comb begin
        enq_pkt             = '0;
        enq_pkt.from_y_cord = my_y_i;
        enq_pkt.from_x_cord = my_x_i;
        if (state == e_issue) begin
            enq_pkt.op     = e_op_config;
            enq_pkt.data   = data_width_p'(cfg_freeze_i);
            enq_pkt.y_cord = cfg_y_i;
            enq_pkt.x_cord = cfg_x_i;
        end else begin
            enq_pkt.op     = e_op_remote_store;
            enq_pkt.addr   = st_addr_i;
            enq_pkt.data   = st_data_i;
            enq_pkt.y_cord = st_y_i;
            enq_pkt.x_cord = st_x_i;
        end
    end

    bsg_two_fifo #(
        .width_p(packet_width_lp)
    ) out_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (st_accept | cfg_accept),
        .data_i  (enq_pkt),
        .ready_o (fifo_ready),
        .v_o     (fifo_v),
        .data_o  (data_o),
        .ready_i (ready_i)
    );

    assign v_o = fifo_v;

    credit_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        credit_return_i |-> (credits != credit_max_lp));

    cfg_dropped_in_fence: assert property (@(posedge clk_i) disable iff (reset_i)
        (state == e_fence) |-> cfg_v_i);

endmodule

// File: tb/tb_bsg_manycore_pkt_encode.sv
// Directed bench for bsg_manycore_pkt_encode with hand-computed packets.
module tb_bsg_manycore_pkt_encode;

    localparam int XW   = 4;
    localparam int YW   = 4;
    localparam int DW   = 32;
    localparam int AW   = 16;
    localparam int MAXC = 4;
    localparam int PW   = 6 + AW + DW + 2 * (XW + YW);
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [XW-1:0] MY_X = 4'd3;
    localparam logic [YW-1:0] MY_Y = 4'd5;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic [XW-1:0] my_x_i = MY_X;
    logic [YW-1:0] my_y_i = MY_Y;
    logic          st_v_i = 1'b0;
    logic [AW-1:0] st_addr_i = '0;
    logic [DW-1:0] st_data_i = '0;
    logic [XW-1:0] st_x_i = '0;
    logic [YW-1:0] st_y_i = '0;
    logic          st_ready_o;
    logic          cfg_v_i = 1'b0;
    logic          cfg_freeze_i = 1'b0;
    logic [XW-1:0] cfg_x_i = '0;
    logic [YW-1:0] cfg_y_i = '0;
    logic          cfg_ready_o;
    logic          credit_return_i = 1'b0;
    logic          v_o;
    logic [PW-1:0] data_o;
    logic          ready_i = 1'b1;
    logic [CW-1:0] out_credits_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bsg_manycore_pkt_encode #(
        .x_cord_width_p   (XW),
        .y_cord_width_p   (YW),
        .data_width_p     (DW),
        .addr_width_p     (AW),
        .max_out_credits_p(MAXC)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .my_x_i         (my_x_i),
        .my_y_i         (my_y_i),
        .st_v_i         (st_v_i),
        .st_addr_i      (st_addr_i),
        .st_data_i      (st_data_i),
        .st_x_i         (st_x_i),
        .st_y_i         (st_y_i),
        .st_ready_o     (st_ready_o),
        .cfg_v_i        (cfg_v_i),
        .cfg_freeze_i   (cfg_freeze_i),
        .cfg_x_i        (cfg_x_i),
        .cfg_y_i        (cfg_y_i),
        .cfg_ready_o    (cfg_ready_o),
        .credit_return_i(credit_return_i),
        .v_o            (v_o),
        .data_o         (data_o),
        .ready_i        (ready_i),
        .out_credits_o  (out_credits_o)
    );

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pkt(input logic [5:0] op, input logic [AW-1:0] a,
                                          input logic [DW-1:0] d, input logic [XW-1:0] x,
                                          input logic [YW-1:0] y);
        return {op, a, d, MY_Y, MY_X, y, x};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [XW-1:0] x, input logic [YW-1:0] y);
        st_v_i    = 1'b1;
        st_addr_i = a;
        st_data_i = d;
        st_x_i    = x;
        st_y_i    = y;
    endtask

    initial begin
        int waited;

        // reset values
        #1 reset_i = 1'b1;
        #1;
        check("rst_v", v_o, 0);
        check("rst_st_ready", st_ready_o, 0);
        check("rst_cfg_ready", cfg_ready_o, 0);
        check("rst_credits", out_credits_o, MAXC);
        step();
        step();
        reset_i = 1'b0;
        #1;

        // single store, latency and field layout
        set_store(16'h0010, 32'hDEADBEEF, 4'd2, 4'd1);
        #1;
        check("st_ready_idle", st_ready_o, 1);
        step();
        st_v_i = 1'b0;
        #1;
        check("st_lat_v", v_o, 1);
        check("st_pkt", data_o, pkt(6'd1, 16'h0010, 32'hDEADBEEF, 4'd2, 4'd1));
        check("st_credit_dec", out_credits_o, 3);
        step();
        check("st_drained", v_o, 0);
        credit_return_i = 1'b1;
        step();
        credit_return_i = 1'b0;
        #1;
        check("st_credit_back", out_credits_o, 4);

        // credit exhaustion with back-to-back stores
        for (int i = 0; i < 4; i++) begin
            set_store(AW'(i), 32'h100 + DW'(i), 4'd1, 4'd1);
            #1;
            check("exh_ready", st_ready_o, 1);
            if (i > 0)
                check("exh_order", data_o, pkt(6'd1, AW'(i - 1), 32'h100 + DW'(i - 1), 4'd1, 4'd1));
            step();
        end
        set_store(16'd4, 32'h104, 4'd1, 4'd1);
        #1;
        check("exh_blocked", st_ready_o, 0);
        check("exh_credits_zero", out_credits_o, 0);
        check("exh_last", data_o, pkt(6'd1, 16'd3, 32'h103, 4'd1, 4'd1));
        credit_return_i = 1'b1;
        #1;
        check("exh_blocked_ret", st_ready_o, 0);
        step();
        credit_return_i = 1'b0;
        #1;
        check("exh_reopen", st_ready_o, 1);
        check("exh_credit_one", out_credits_o, 1);
        step();
        st_v_i = 1'b0;
        #1;
        check("exh_fifth", data_o, pkt(6'd1, 16'd4, 32'h104, 4'd1, 4'd1));
        check("exh_credits_end", out_credits_o, 0);
        credit_return_i = 1'b1;
        repeat (4) step();
        credit_return_i = 1'b0;
        #1;
        check("exh_restored", out_credits_o, 4);

        // config fence behind 3 outstanding stores, tie with a store request
        for (int i = 0; i < 3; i++) begin
            set_store(16'h0040, 32'h200 + DW'(i), 4'd2, 4'd1);
            step();
        end
        st_v_i = 1'b0;
        step();
        check("fence_credits", out_credits_o, 1);
        cfg_v_i      = 1'b1;
        cfg_freeze_i = 1'b1;
        cfg_x_i      = 4'd1;
        cfg_y_i      = 4'd2;
        set_store(16'h0020, 32'h000000AA, 4'd2, 4'd1);
        #1;
        check("tie_st_ready", st_ready_o, 0);
        check("tie_cfg_ready", cfg_ready_o, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            check("fence_st_ready", st_ready_o, 0);
            check("fence_cfg_ready", cfg_ready_o, 0);
            step();
        end
        credit_return_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("fence_ret_cfg", cfg_ready_o, 0);
            step();
        end
        credit_return_i = 1'b0;
        waited = 0;
        while (!cfg_ready_o && waited < 10) begin
            step();
            waited++;
        end
        check("cfg_ready_seen", cfg_ready_o, 1);
        check("cfg_wait_cycles", waited, 1);
        check("issue_st_ready", st_ready_o, 0);
        step();
        cfg_v_i = 1'b0;
        #1;
        check("cfg_pulse_once", cfg_ready_o, 0);
        check("cfg_v", v_o, 1);
        check("cfg_pkt", data_o, pkt(6'd2, 16'h0000, 32'h00000001, 4'd1, 4'd2));
        check("tie_st_after", st_ready_o, 1);
        step();
        st_v_i = 1'b0;
        #1;
        check("tie_store_pkt", data_o, pkt(6'd1, 16'h0020, 32'h000000AA, 4'd2, 4'd1));
        check("tie_credits", out_credits_o, 3);
        step();
        credit_return_i = 1'b1;
        step();
        credit_return_i = 1'b0;

        // backpressure with the queue full
        ready_i = 1'b0;
        set_store(16'h0030, 32'hA0, 4'd1, 4'd2);
        step();
        set_store(16'h0031, 32'hB0, 4'd1, 4'd2);
        step();
        set_store(16'h0032, 32'hC0, 4'd1, 4'd2);
        #1;
        for (int k = 0; k < 10; k++) begin
            check("bp_st_ready", st_ready_o, 0);
            check("bp_hold", data_o, pkt(6'd1, 16'h0030, 32'hA0, 4'd1, 4'd2));
            step();
        end
        check("bp_credits", out_credits_o, 2);
        ready_i = 1'b1;
        st_v_i  = 1'b0;
        #1;
        check("bp_full_on_release", st_ready_o, 0);
        step();
        check("bp_second", data_o, pkt(6'd1, 16'h0031, 32'hB0, 4'd1, 4'd2));
        check("bp_second_v", v_o, 1);
        step();
        check("bp_empty", v_o, 0);
        credit_return_i = 1'b1;
        repeat (2) step();
        credit_return_i = 1'b0;

        // reset with two queued packets and one credit left
        set_store(16'h0050, 32'h50, 4'd0, 4'd0);
        step();
        st_v_i = 1'b0;
        step();
        ready_i = 1'b0;
        set_store(16'h0051, 32'h51, 4'd0, 4'd0);
        step();
        set_store(16'h0052, 32'h52, 4'd0, 4'd0);
        step();
        st_v_i = 1'b0;
        #1;
        check("prerst_credits", out_credits_o, 1);
        check("prerst_v", v_o, 1);
        reset_i = 1'b1;
        #1;
        check("mid_rst_v", v_o, 0);
        check("mid_rst_credits", out_credits_o, MAXC);
        check("mid_rst_st_ready", st_ready_o, 0);
        step();
        reset_i = 1'b0;
        ready_i = 1'b1;
        set_store(16'h0060, 32'h60, 4'd3, 4'd3);
        #1;
        check("post_rst_v", v_o, 0);
        check("post_rst_idle", st_ready_o, 1);
        check("post_rst_cfg_ready", cfg_ready_o, 0);
        step();
        st_v_i = 1'b0;
        #1;
        check("post_rst_pkt", data_o, pkt(6'd1, 16'h0060, 32'h60, 4'd3, 4'd3));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
